reg_writeback_queue: RTL and testbench

//  Write-side companion to the 16x16 register file. Buffers register writes from
//  the execute/memory stages in a small FIFO. Retires at most one write per cycle

---
 rtl/proc_pkg.sv | 19 +
 rtl/wbq_match.sv | 62 ++++++
 rtl/reg_writeback_queue.sv | 171 +++++++++++++++++
 tb/tb_reg_writeback_queue.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/proc_pkg.sv
// -----------------------------------------------------------------------------
// proc_pkg
//   Shared processor definitions used by the register write-back queue:
//   register index/data widths, the hardwired-zero register index and the
//   queued write-back entry layout {rd, data}.
// -----------------------------------------------------------------------------
package proc_pkg;

    localparam int REG_ADDR_W = 4;
    localparam int REG_DATA_W = 16;

    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 4'd0;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [REG_DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wbq_match.sv
// -----------------------------------------------------------------------------
// wbq_match
//   Combinational hazard comparator for one decode source port. Entries are
//   presented in age order (index 0 = oldest, DEPTH-1 = youngest) together
//   with per-entry valid bits.
//
// Optional feature macro: WBQ_BYPASS_EN (adds hit_o / fwd_o).
//
// Ports
//   rs_i        in   ADDR_W        source register index to look up
//   ent_rd_i    in   DEPTH*ADDR_W  age-ordered destination indices
//   ent_valid_i in   DEPTH         age-ordered valid bits
//   pend_o      out  1             some valid entry targets rs_i (never for R0)
//   ent_data_i  in   DEPTH*DATA_W  age-ordered data      (WBQ_BYPASS_EN only)
//   hit_o       out  1             same as pend_o        (WBQ_BYPASS_EN only)
//   fwd_o       out  DATA_W        data of youngest match (WBQ_BYPASS_EN only)
// -----------------------------------------------------------------------------
module wbq_match #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4
) (
    input  logic [ADDR_W-1:0]       rs_i,
    input  logic [DEPTH*ADDR_W-1:0] ent_rd_i,
    input  logic [DEPTH-1:0]        ent_valid_i,
    output logic                    pend_o
`ifdef WBQ_BYPASS_EN
    ,
    input  logic [DEPTH*DATA_W-1:0] ent_data_i,
    output logic                    hit_o,
    output logic [DATA_W-1:0]       fwd_o
`endif
);

    logic [DEPTH-1:0] match;

    // R0 is never a real hazard, so a zero index suppresses every match.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_cmp
            assign match[gi] = ent_valid_i[gi]
                             && (ent_rd_i[gi*ADDR_W +: ADDR_W] == rs_i)
                             && (rs_i != '0);
        end
    endgenerate

    assign pend_o = |match;

`ifdef WBQ_BYPASS_EN
    assign hit_o = pend_o;

    // Scan oldest to youngest so the youngest match overwrites older ones.
    always_comb begin
        fwd_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (match[i]) begin
                fwd_o = ent_data_i[i*DATA_W +: DATA_W];
            end
        end
    end
`endif

endmodule

// File: rtl/reg_writeback_queue.sv
// -----------------------------------------------------------------------------
// reg_writeback_queue
//   Write-side companion to the register file. Buffers register writes in a
//   small FIFO, retires at most one per cycle onto the reg-file write port and
//   reports which decode source registers still have writes in flight.
//
// Optional feature macro: WBQ_BYPASS_EN (adds rs1/rs2 hit + forwarded data).
//
// Ports
//   clk        in   1        rising-edge clock
//   reset      in   1        synchronous, active-low reset
//   in_valid   in   1        producer presents a write
//   in_rd      in   ADDR_W   destination register (R0 writes are dropped)
//   in_data    in   DATA_W   value to write
//   in_ready   out  1        queue can accept (count < DEPTH)
//   rf_busy    in   1        reg-file write port unavailable this cycle
//   rf_we      out  1        write enable to reg file
//   rf_rd      out  ADDR_W   write address (head entry, 0 when empty)
//   rf_wdata   out  DATA_W   write data (head entry, 0 when empty)
//   rs1, rs2   in   ADDR_W   decode source indices to check
//   rs1_pend   out  1        a queued write targets rs1
//   rs2_pend   out  1        a queued write targets rs2
//   count      out  clog2(DEPTH)+1  occupied entries
//   rs1_hit, rs2_hit  out 1       (WBQ_BYPASS_EN) match present
//   rs1_fwd, rs2_fwd  out DATA_W  (WBQ_BYPASS_EN) youngest matching data
//
// Entries use the proc_pkg wb_entry_t layout, so ADDR_W/DATA_W are expected
// to equal REG_ADDR_W/REG_DATA_W.
// -----------------------------------------------------------------------------
module reg_writeback_queue
    import proc_pkg::*;
#(
    parameter int DATA_W = REG_DATA_W,
    parameter int ADDR_W = REG_ADDR_W,
    parameter int DEPTH  = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    input  logic [ADDR_W-1:0]      in_rd,
    input  logic [DATA_W-1:0]      in_data,
    output logic                   in_ready,
    input  logic                   rf_busy,
    output logic                   rf_we,
    output logic [ADDR_W-1:0]      rf_rd,
    output logic [DATA_W-1:0]      rf_wdata,
    input  logic [ADDR_W-1:0]      rs1,
    input  logic [ADDR_W-1:0]      rs2,
    output logic                   rs1_pend,
    output logic                   rs2_pend,
    output logic [$clog2(DEPTH):0] count
`ifdef WBQ_BYPASS_EN
    ,
    output logic                   rs1_hit,
    output logic                   rs2_hit,
    output logic [DATA_W-1:0]      rs1_fwd,
    output logic [DATA_W-1:0]      rs2_fwd
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    wb_entry_t        mem_q [DEPTH];
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic not_empty;
    logic push;
    logic pop;

    assign not_empty = (count_q != '0);
    assign in_ready  = (count_q < CNT_W'(DEPTH));
    assign rf_we     = not_empty && !rf_busy;
    assign pop       = rf_we;
    // R0 writes are handshaken normally but never occupy an entry.
    assign push      = in_valid && in_ready && (in_rd != REG_ZERO);

    assign rf_rd    = not_empty ? mem_q[rd_ptr_q].rd   : '0;
    assign rf_wdata = not_empty ? mem_q[rd_ptr_q].data : '0;
    assign count    = count_q;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        valid_d  = valid_q;
        if (pop) begin
            rd_ptr_d          = rd_ptr_q + 1'b1;
            valid_d[rd_ptr_q] = 1'b0;
        end
        if (push) begin
            wr_ptr_d          = wr_ptr_q + 1'b1;
            valid_d[wr_ptr_q] = 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Payload storage is not reset: validity and count gate every read.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            valid_q  <= valid_d;
            if (push) begin
                mem_q[wr_ptr_q] <= '{rd: in_rd, data: in_data};
            end
        end
    end

    // Present entries oldest-first so the comparator can pick the youngest match.
    logic [DEPTH*ADDR_W-1:0] ord_rd;
    logic [DEPTH*DATA_W-1:0] ord_data;
    logic [DEPTH-1:0]        ord_valid;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_order
            logic [PTR_W-1:0] slot;
            assign slot                          = rd_ptr_q + PTR_W'(gi);
            assign ord_rd[gi*ADDR_W +: ADDR_W]   = mem_q[slot].rd;
            assign ord_data[gi*DATA_W +: DATA_W] = mem_q[slot].data;
            assign ord_valid[gi]                 = valid_q[slot];
        end
    endgenerate

`ifndef WBQ_BYPASS_EN
    // Data is only needed for forwarding.
    logic unused_ord_data;
    assign unused_ord_data = ^ord_data;
`endif

    wbq_match #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) u_match_rs1 (
        .rs_i        (rs1),
        .ent_rd_i    (ord_rd),
        .ent_valid_i (ord_valid),
        .pend_o      (rs1_pend)
`ifdef WBQ_BYPASS_EN
        ,
        .ent_data_i  (ord_data),
        .hit_o       (rs1_hit),
        .fwd_o       (rs1_fwd)
`endif
    );

    wbq_match #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) u_match_rs2 (
        .rs_i        (rs2),
        .ent_rd_i    (ord_rd),
        .ent_valid_i (ord_valid),
        .pend_o      (rs2_pend)
`ifdef WBQ_BYPASS_EN
        ,
        .ent_data_i  (ord_data),
        .hit_o       (rs2_hit),
        .fwd_o       (rs2_fwd)
`endif
    );

endmodule

// File: tb/tb_reg_writeback_queue.sv
// -----------------------------------------------------------------------------
// tb_reg_writeback_queue
//   Directed, table-driven bench for reg_writeback_queue. Each table row holds
//   the inputs for one cycle and the outputs expected during that cycle (before
//   the edge commits it). A hand-written burst sequence follows.
//   Define WBQ_BYPASS_EN to also check the forwarding ports.
// -----------------------------------------------------------------------------
module tb_reg_writeback_queue;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic [3:0]  in_rd;
    logic [15:0] in_data;
    logic        in_ready;
    logic        rf_busy;
    logic        rf_we;
    logic [3:0]  rf_rd;
    logic [15:0] rf_wdata;
    logic [3:0]  rs1, rs2;
    logic        rs1_pend, rs2_pend;
    logic [2:0]  count;
`ifdef WBQ_BYPASS_EN
    logic        rs1_hit, rs2_hit;
    logic [15:0] rs1_fwd, rs2_fwd;
`endif

    reg_writeback_queue dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_rd    (in_rd),
        .in_data  (in_data),
        .in_ready (in_ready),
        .rf_busy  (rf_busy),
        .rf_we    (rf_we),
        .rf_rd    (rf_rd),
        .rf_wdata (rf_wdata),
        .rs1      (rs1),
        .rs2      (rs2),
        .rs1_pend (rs1_pend),
        .rs2_pend (rs2_pend),
        .count    (count)
`ifdef WBQ_BYPASS_EN
        ,
        .rs1_hit  (rs1_hit),
        .rs2_hit  (rs2_hit),
        .rs1_fwd  (rs1_fwd),
        .rs2_fwd  (rs2_fwd)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst_n;
        logic        vld;
        logic [3:0]  rd;
        logic [15:0] data;
        logic        busy;
        logic [3:0]  s1;
        logic [3:0]  s2;
        logic        e_ready;
        logic        e_we;
        logic [3:0]  e_rd;
        logic [15:0] e_wdata;
        logic        e_p1;
        logic        e_p2;
        logic [2:0]  e_cnt;
        logic [15:0] e_f1;
        logic [15:0] e_f2;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic vec_t mk(
        input logic rst_n, input logic vld, input logic [3:0] rd, input logic [15:0] data,
        input logic busy, input logic [3:0] s1, input logic [3:0] s2,
        input logic e_ready, input logic e_we, input logic [3:0] e_rd, input logic [15:0] e_wdata,
        input logic e_p1, input logic e_p2, input logic [2:0] e_cnt,
        input logic [15:0] e_f1, input logic [15:0] e_f2);
        vec_t v;
        v.rst_n = rst_n; v.vld = vld; v.rd = rd; v.data = data; v.busy = busy;
        v.s1 = s1; v.s2 = s2; v.e_ready = e_ready; v.e_we = e_we; v.e_rd = e_rd;
        v.e_wdata = e_wdata; v.e_p1 = e_p1; v.e_p2 = e_p2; v.e_cnt = e_cnt;
        v.e_f1 = e_f1; v.e_f2 = e_f2;
        return v;
    endfunction

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s step %0d: got %0h expected %0h", nm, idx, act, exp);
        end
    endtask

    initial begin
        //            rst vld rd  data     bsy s1 s2   rdy we wrd wdata    p1 p2 cnt f1       f2
        // Reset held two cycles with a write offered
        vecs.push_back(mk(0, 1, 5, 16'h1234, 0, 5, 0,   1, 0, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000));
        vecs.push_back(mk(0, 1, 5, 16'h1234, 0, 5, 0,   1, 0, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000));
        // Single write, one-cycle latency, pend clears after retire
        vecs.push_back(mk(1, 1, 3, 16'hBEEF, 0, 3, 0,   1, 0, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000));
        vecs.push_back(mk(1, 0, 0, 16'h0000, 0, 3, 3,   1, 1, 3, 16'hBEEF, 1, 1, 1, 16'hBEEF, 16'hBEEF));
        vecs.push_back(mk(1, 0, 0, 16'h0000, 0, 3, 3,   1, 0, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000));
        // Fill under rf_busy, fifth write held, then drain in order
        vecs.push_back(mk(1, 1, 1, 16'h0101, 1, 1, 2,   1, 0, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000));
        vecs.push_back(mk(1, 1, 2, 16'h0202, 1, 1, 2,   1, 0, 1, 16'h0101, 1, 0, 1, 16'h0101, 16'h0000));
        vecs.push_back(mk(1, 1, 3, 16'h0303, 1, 1, 2,   1, 0, 1, 16'h0101, 1, 1, 2, 16'h0101, 16'h0202));
        vecs.push_back(mk(1, 1, 4, 16'h0404, 1, 4, 3,   1, 0, 1, 16'h0101, 0, 1, 3, 16'h0000, 16'h0303));
        vecs.push_back(mk(1, 1, 5, 16'h0505, 1, 4, 5,   0, 0, 1, 16'h0101, 1, 0, 4, 16'h0404, 16'h0000));
        vecs.push_back(mk(1, 1, 5, 16'h0505, 1, 4, 5,   0, 0, 1, 16'h0101, 1, 0, 4, 16'h0404, 16'h0000));
        vecs.push_back(mk(1, 1, 5, 16'h0505, 0, 1, 5,   0, 1, 1, 16'h0101, 1, 0, 4, 16'h0101, 16'h0000));
        vecs.push_back(mk(1, 1, 5, 16'h0505, 0, 1, 2,   1, 1, 2, 16'h0202, 0, 1, 3, 16'h0000, 16'h0202));
        vecs.push_back(mk(1, 0, 0, 16'h0000, 0, 5, 3,   1, 1, 3, 16'h0303, 1, 1, 3, 16'h0505, 16'h0303));
        vecs.push_back(mk(1, 0, 0, 16'h0000, 0, 5, 3,   1, 1, 4, 16'h0404, 1, 0, 2, 16'h0505, 16'h0000));
        vecs.push_back(mk(1, 0, 0, 16'h0000, 0, 5, 4,   1, 1, 5, 16'h0505, 1, 0, 1, 16'h0505, 16'h0000));
        vecs.push_back(mk(1, 0, 0, 16'h0000, 0, 5, 4,   1, 0, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000));
        // R0 write is accepted and dropped
        vecs.push_back(mk(1, 1, 0, 16'hFFFF, 0, 0, 0,   1, 0, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000));
        vecs.push_back(mk(1, 0, 0, 16'h0000, 0, 0, 0,   1, 0, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000));
        // Same destination twice: arrival order, youngest forwarded
        vecs.push_back(mk(1, 1, 7, 16'h0011, 1, 0, 7,   1, 0, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000));
        vecs.push_back(mk(1, 1, 7, 16'h0022, 1, 7, 7,   1, 0, 7, 16'h0011, 1, 1, 1, 16'h0011, 16'h0011));
        vecs.push_back(mk(1, 0, 0, 16'h0000, 1, 7, 7,   1, 0, 7, 16'h0011, 1, 1, 2, 16'h0022, 16'h0022));
        vecs.push_back(mk(1, 0, 0, 16'h0000, 0, 7, 7,   1, 1, 7, 16'h0011, 1, 1, 2, 16'h0022, 16'h0022));
        vecs.push_back(mk(1, 0, 0, 16'h0000, 0, 7, 7,   1, 1, 7, 16'h0022, 1, 1, 1, 16'h0022, 16'h0022));
        vecs.push_back(mk(1, 0, 0, 16'h0000, 0, 7, 7,   1, 0, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000));
        // Reset in the middle of a drain discards the remaining entries
        vecs.push_back(mk(1, 1, 9, 16'h0909, 1, 9, 10,  1, 0, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000));
        vecs.push_back(mk(1, 1, 10, 16'h0A0A, 1, 9, 10, 1, 0, 9, 16'h0909, 1, 0, 1, 16'h0909, 16'h0000));
        vecs.push_back(mk(1, 1, 11, 16'h0B0B, 1, 9, 10, 1, 0, 9, 16'h0909, 1, 1, 2, 16'h0909, 16'h0A0A));
        vecs.push_back(mk(1, 0, 0, 16'h0000, 0, 9, 11,  1, 1, 9, 16'h0909, 1, 1, 3, 16'h0909, 16'h0B0B));
        vecs.push_back(mk(0, 0, 0, 16'h0000, 0, 10, 11, 1, 1, 10, 16'h0A0A, 1, 1, 2, 16'h0A0A, 16'h0B0B));
        vecs.push_back(mk(1, 0, 0, 16'h0000, 0, 10, 11, 1, 0, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000));
        vecs.push_back(mk(1, 0, 0, 16'h0000, 0, 10, 11, 1, 0, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000));

        reset    = 1'b0;
        in_valid = 1'b0;
        in_rd    = '0;
        in_data  = '0;
        rf_busy  = 1'b0;
        rs1      = '0;
        rs2      = '0;
        @(posedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            reset    = vecs[i].rst_n;
            in_valid = vecs[i].vld;
            in_rd    = vecs[i].rd;
            in_data  = vecs[i].data;
            rf_busy  = vecs[i].busy;
            rs1      = vecs[i].s1;
            rs2      = vecs[i].s2;
            #1;
            $display("vec %0d: rst_n=%0b in=%0b/%0d/%h busy=%0b -> rdy=%0b we=%0b rd=%0d wd=%h p=%0b%0b cnt=%0d",
                     i, reset, in_valid, in_rd, in_data, rf_busy, in_ready, rf_we, rf_rd, rf_wdata,
                     rs1_pend, rs2_pend, count);
            chk("in_ready", i, 32'(in_ready), 32'(vecs[i].e_ready));
            chk("rf_we",    i, 32'(rf_we),    32'(vecs[i].e_we));
            chk("rf_rd",    i, 32'(rf_rd),    32'(vecs[i].e_rd));
            chk("rf_wdata", i, 32'(rf_wdata), 32'(vecs[i].e_wdata));
            chk("rs1_pend", i, 32'(rs1_pend), 32'(vecs[i].e_p1));
            chk("rs2_pend", i, 32'(rs2_pend), 32'(vecs[i].e_p2));
            chk("count",    i, 32'(count),    32'(vecs[i].e_cnt));
`ifdef WBQ_BYPASS_EN
            chk("rs1_hit",  i, 32'(rs1_hit),  32'(vecs[i].e_p1));
            chk("rs2_hit",  i, 32'(rs2_hit),  32'(vecs[i].e_p2));
            chk("rs1_fwd",  i, 32'(rs1_fwd),  32'(vecs[i].e_f1));
            chk("rs2_fwd",  i, 32'(rs2_fwd),  32'(vecs[i].e_f2));
`endif
        end

        // Back-to-back burst with the write port free: each write retires the
        // cycle after it is pushed, occupancy stays at one, and pointers wrap.
        begin
            int retired;
            logic        exp_we;
            logic [3:0]  exp_rd;
            retired = 0;
            rs1     = '0;
            rs2     = '0;
            for (int s = 0; s < 8; s++) begin
                @(negedge clk);
                reset    = 1'b1;
                rf_busy  = 1'b0;
                in_valid = (s < 4);
                in_rd    = 4'(12 + s);
                in_data  = 16'h1000 + 16'(12 + s);
                #1;
                exp_we = (s >= 1) && (s <= 4);
                exp_rd = 4'(11 + s);
                $display("burst %0d: in=%0b/%0d -> we=%0b rd=%0d wd=%h cnt=%0d",
                         s, in_valid, in_rd, rf_we, rf_rd, rf_wdata, count);
                chk("burst_we",    s, 32'(rf_we), 32'(exp_we));
                chk("burst_count", s, 32'(count), exp_we ? 32'd1 : 32'd0);
                if (rf_we) begin
                    retired++;
                    chk("burst_rd",    s, 32'(rf_rd),    32'(exp_rd));
                    chk("burst_wdata", s, 32'(rf_wdata), 32'h1000 + 32'(exp_rd));
                end
            end
            chk("burst_retired", 0, 32'(retired), 32'd4);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
